// File: rtl/lane_mux_pkg.sv
// Shared types and constants for the lane serializer.
package lane_mux_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   localparam int DEF_NUM_LANES = 4;
   localparam int DEF_DATA_W    = 8;
   localparam int DEF_SKIP      = 0;
   localparam int FRAME_W       = 8;

   // Lane index never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/lane_mux_param_lane_pick.sv
// Priority finder: lowest valid lane above base (or at base when incl).
module lane_pick
   import lane_mux_pkg::*;
#(
   parameter int NUM_LANES = DEF_NUM_LANES,
   parameter int IDX_W     = idx_width(NUM_LANES)
) (
   input  logic [NUM_LANES-1:0] valid,
   input  logic [IDX_W-1:0]     base,
   input  logic                 incl,
   output logic [IDX_W-1:0]     idx,
   output logic                 none
);

   always_comb begin
      idx  = '0;
      none = 1'b1;
      for (int k = NUM_LANES - 1; k >= 0; k--) begin
         if (valid[k] && (k > int'(base) || (incl && k == int'(base)))) begin
            idx  = IDX_W'(k);
            none = 1'b0;
         end
      end
   end

endmodule

// File: rtl/lane_mux_param.sv
// Serializes a parallel lane set onto one registered lane per cycle.
module lane_mux_param
   import lane_mux_pkg::*;
#(
   parameter int NUM_LANES    = DEF_NUM_LANES,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int SKIP_INVALID = DEF_SKIP
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_LANES*DATA_W-1:0] in_data,
   input  logic [NUM_LANES-1:0]        in_valid,
   input  logic                        in_load,
   output logic                        in_ready,
   output logic [DATA_W-1:0]           out_data,
   output logic                        out_valid,
   output logic [FRAME_W-1:0]          frame_cnt
);

   localparam int IW = idx_width(NUM_LANES);

   state_t                      state, state_n;
   logic [IW-1:0]               idx, idx_n;
   logic [NUM_LANES*DATA_W-1:0] hold_data, hold_data_n;
   logic [NUM_LANES-1:0]        hold_valid, hold_valid_n;
   logic [DATA_W-1:0]           od_n;
   logic                        ov_n;
   logic [IW-1:0]               first_idx, next_idx;
   logic                        first_none, next_none;
   logic                        last, accept;
   logic [1:0]                  cnt_inc;

   // Flat mode walks every lane; skip mode hops between valid lanes.
   generate
      if (SKIP_INVALID != 0) begin : g_skip
         lane_pick #(.NUM_LANES(NUM_LANES), .IDX_W(IW)) u_first (
            .valid (in_valid),
            .base  ('0),
            .incl  (1'b1),
            .idx   (first_idx),
            .none  (first_none)
         );
         lane_pick #(.NUM_LANES(NUM_LANES), .IDX_W(IW)) u_next (
            .valid (hold_valid),
            .base  (idx),
            .incl  (1'b0),
            .idx   (next_idx),
            .none  (next_none)
         );
      end else begin : g_flat
         assign first_idx  = '0;
         assign first_none = 1'b0;
         assign next_idx   = idx + IW'(1);
         assign next_none  = (idx == IW'(NUM_LANES - 1));
      end
   endgenerate

   assign last     = (state == SEND) && next_none;
   assign in_ready = (state == IDLE) || last;
   assign accept   = in_load && in_ready;

   always_comb begin
      state_n      = state;
      idx_n        = idx;
      hold_data_n  = hold_data;
      hold_valid_n = hold_valid;
      od_n         = '0;
      ov_n         = 1'b0;
      cnt_inc      = last ? 2'd1 : 2'd0;
      if (accept) begin
         hold_data_n  = in_data;
         hold_valid_n = in_valid;
         if (first_none) begin
            state_n = IDLE;
            idx_n   = '0;
            cnt_inc = cnt_inc + 2'd1;
         end else begin
            state_n = SEND;
            idx_n   = first_idx;
            ov_n    = in_valid[first_idx];
            od_n    = ov_n ? in_data[first_idx*DATA_W +: DATA_W] : '0;
         end
      end else if (state == SEND && !last) begin
         idx_n = next_idx;
         ov_n  = hold_valid[next_idx];
         od_n  = ov_n ? hold_data[next_idx*DATA_W +: DATA_W] : '0;
      end else begin
         state_n = IDLE;
         idx_n   = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         idx        <= '0;
         hold_data  <= '0;
         hold_valid <= '0;
         out_data   <= '0;
         out_valid  <= 1'b0;
         frame_cnt  <= '0;
      end else begin
         state      <= state_n;
         idx        <= idx_n;
         hold_data  <= hold_data_n;
         hold_valid <= hold_valid_n;
         out_data   <= od_n;
         out_valid  <= ov_n;
         frame_cnt  <= frame_cnt + FRAME_W'(cnt_inc);
      end
   end

endmodule

// File: tb/tb_lane_mux_param.sv
// Directed checks of the lane serializer in flat, skip and wide configs.
module tb_lane_mux_param;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   logic [31:0]  d0, d1;
   logic [3:0]   v0, v1;
   logic         l0, l1, r0, r1, ov0, ov1;
   logic [7:0]   od0, od1, fc0, fc1, fc2;
   logic [127:0] d2;
   logic [7:0]   v2;
   logic         l2, r2, ov2;
   logic [15:0]  od2;

   lane_mux_param #(.NUM_LANES(4), .DATA_W(8), .SKIP_INVALID(0)) u0 (
      .clk(clk), .reset(rst_n), .in_data(d0), .in_valid(v0), .in_load(l0),
      .in_ready(r0), .out_data(od0), .out_valid(ov0), .frame_cnt(fc0)
   );
   lane_mux_param #(.NUM_LANES(4), .DATA_W(8), .SKIP_INVALID(1)) u1 (
      .clk(clk), .reset(rst_n), .in_data(d1), .in_valid(v1), .in_load(l1),
      .in_ready(r1), .out_data(od1), .out_valid(ov1), .frame_cnt(fc1)
   );
   lane_mux_param #(.NUM_LANES(8), .DATA_W(16), .SKIP_INVALID(1)) u2 (
      .clk(clk), .reset(rst_n), .in_data(d2), .in_valid(v2), .in_load(l2),
      .in_ready(r2), .out_data(od2), .out_valid(ov2), .frame_cnt(fc2)
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic e0(input string t, input logic [7:0] d, input logic v,
                     input logic r);
      check({t, ".d"}, 64'(od0), 64'(d));
      check({t, ".v"}, 64'(ov0), 64'(v));
      check({t, ".r"}, 64'(r0), 64'(r));
      tick();
   endtask

   task automatic e1(input string t, input logic [7:0] d, input logic v,
                     input logic r);
      check({t, ".d"}, 64'(od1), 64'(d));
      check({t, ".v"}, 64'(ov1), 64'(v));
      check({t, ".r"}, 64'(r1), 64'(r));
      tick();
   endtask

   task automatic load0(input logic [31:0] d, input logic [3:0] v);
      d0 = d; v0 = v; l0 = 1'b1;
      tick();
      l0 = 1'b0;
   endtask

   task automatic load1(input logic [31:0] d, input logic [3:0] v);
      d1 = d; v1 = v; l1 = 1'b1;
      tick();
      l1 = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   logic [15:0]  q[$];
   logic [127:0] cd;
   logic [7:0]   cv;
   int s, pushed, popped, drain, pause;

   initial begin
      d0 = '0; v0 = '0; l0 = 1'b0;
      d1 = '0; v1 = '0; l1 = 1'b0;
      d2 = '0; v2 = '0; l2 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst.od0", 64'(od0), 64'h0);
      check("rst.ov0", 64'(ov0), 64'h0);
      check("rst.r0", 64'(r0), 64'h1);
      check("rst.fc0", 64'(fc0), 64'h0);
      check("rst.r1", 64'(r1), 64'h1);
      check("rst.ov2", 64'(ov2), 64'h0);
      rst_n = 1'b1;
      tick();

      // flat mode: all lanes valid
      check("t1.rdy", 64'(r0), 64'h1);
      load0(32'h44332211, 4'hF);
      e0("t1a", 8'h11, 1, 0);
      e0("t1b", 8'h22, 1, 0);
      e0("t1c", 8'h33, 1, 0);
      e0("t1d", 8'h44, 1, 1);
      e0("t1i", 8'h00, 0, 1);
      check("t1.fc", 64'(fc0), 64'd1);

      // flat mode: invalid lanes become idle beats
      load0(32'h44332211, 4'b0101);
      e0("t2a", 8'h11, 1, 0);
      e0("t2b", 8'h00, 0, 0);
      e0("t2c", 8'h33, 1, 0);
      e0("t2d", 8'h00, 0, 1);
      check("t2.fc", 64'(fc0), 64'd2);

      // back-to-back sets; second set offered while not ready
      d0 = 32'h44332211; v0 = 4'hF; l0 = 1'b1;
      tick();
      d0 = 32'h88776655;
      e0("t3a", 8'h11, 1, 0);
      e0("t3b", 8'h22, 1, 0);
      e0("t3c", 8'h33, 1, 0);
      e0("t3d", 8'h44, 1, 1);
      l0 = 1'b0;
      e0("t3e", 8'h55, 1, 0);
      e0("t3f", 8'h66, 1, 0);
      e0("t3g", 8'h77, 1, 0);
      e0("t3h", 8'h88, 1, 1);
      e0("t3i", 8'h00, 0, 1);
      check("t3.fc", 64'(fc0), 64'd4);

      // skip mode
      load1(32'h44332211, 4'b1010);
      e1("t4a", 8'h22, 1, 0);
      e1("t4b", 8'h44, 1, 1);
      check("t4.fc", 64'(fc1), 64'd1);
      e1("t4i", 8'h00, 0, 1);
      load1(32'h44332211, 4'b0000);
      check("t4z.v", 64'(ov1), 64'h0);
      check("t4z.r", 64'(r1), 64'h1);
      check("t4z.fc", 64'(fc1), 64'd2);
      load1(32'h44332211, 4'b0100);
      e1("t4s", 8'h33, 1, 1);
      check("t4s.fc", 64'(fc1), 64'd3);
      d1 = 32'h44332211; v1 = 4'b1001; l1 = 1'b1;
      tick();
      d1 = 32'h88776655; v1 = 4'b0110;
      e1("t4p", 8'h11, 1, 0);
      e1("t4q", 8'h44, 1, 1);
      l1 = 1'b0;
      e1("t4r", 8'h66, 1, 0);
      e1("t4t", 8'h77, 1, 1);
      check("t4b2b.fc", 64'(fc1), 64'd5);
      load1(32'h44332211, 4'b0001);
      check("t4l.d", 64'(od1), 64'h11);
      check("t4l.r", 64'(r1), 64'h1);
      l1 = 1'b1; v1 = 4'b0000;
      tick();
      l1 = 1'b0;
      check("t4l.v", 64'(ov1), 64'h0);
      check("t4l.fc", 64'(fc1), 64'd7);

      // reset mid-set
      load0(32'h44332211, 4'hF);
      e0("t5a", 8'h11, 1, 0);
      check("t5.pre", 64'(od0), 64'h22);
      rst_n = 1'b0;
      #1;
      check("t5.od", 64'(od0), 64'h0);
      check("t5.ov", 64'(ov0), 64'h0);
      check("t5.r", 64'(r0), 64'h1);
      check("t5.fc", 64'(fc0), 64'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      load0(32'hDDCCBBAA, 4'hF);
      e0("t5b", 8'hAA, 1, 0);
      e0("t5c", 8'hBB, 1, 0);
      e0("t5d", 8'hCC, 1, 0);
      e0("t5e", 8'hDD, 1, 1);
      e0("t5i", 8'h00, 0, 1);
      check("t5.fc1", 64'(fc0), 64'd1);

      // wide config against a scoreboard, 256 sets
      s = 0; pushed = 0; popped = 0; drain = 0; pause = 0;
      cd = {$urandom, $urandom, $urandom, $urandom};
      cv = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      for (int cyc = 0; cyc < 6000; cyc++) begin
         if (ov2) begin
            check("sb.any", 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) begin
               check("sb.lane", 64'(od2), 64'(q.pop_front()));
               popped++;
            end
         end
         if (s == 128 && pause < 12) begin
            l2 = 1'b0;
            pause++;
            if (pause == 12) check("sb.fc_mid", 64'(fc2), 64'd128);
         end else if (s < 256) begin
            l2 = 1'b1; d2 = cd; v2 = cv;
            if (r2) begin
               for (int k = 0; k < 8; k++)
                  if (cv[k]) begin
                     q.push_back(cd[k*16 +: 16]);
                     pushed++;
                  end
               s++;
               cd = {$urandom, $urandom, $urandom, $urandom};
               cv = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            end
         end else begin
            l2 = 1'b0;
            drain++;
         end
         tick();
         if (drain > 12) break;
      end
      check("sb.sets", 64'(s), 64'd256);
      check("sb.left", 64'(q.size()), 64'd0);
      check("sb.count", 64'(popped), 64'(pushed));
      check("sb.fc_wrap", 64'(fc2), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
